// File: rtl/hex_digit_feeder_if.sv
// Display-port interface between the RV32I memory-mapped write side and the
// hex_digit_feeder. The master writes values; the slave returns the digit codes
// and status seen by the 7-segment decoders.
interface hex_digit_feeder_if #(
    parameter int DIGITS = 8,
    parameter int VAL_W  = 32
);
    logic                wr_en;
    logic [VAL_W-1:0]    wr_data;
    logic                dec_mode;
    logic [4*DIGITS-1:0] digit_o;
    logic [DIGITS-1:0]   blank_o;
    logic                busy;
    logic                done;
    logic                ovf;

    modport master (
        output wr_en, wr_data, dec_mode,
        input  digit_o, blank_o, busy, done, ovf
    );

    modport slave (
        input  wr_en, wr_data, dec_mode,
        output digit_o, blank_o, busy, done, ovf
    );
endinterface

// File: rtl/hex_digit_feeder.sv
// hex_digit_feeder: captures a 32-bit display value and produces DIGITS
// registered 4-bit digit codes. Hex mode passes nibbles through; decimal mode
// runs a one-bit-per-cycle double-dabble conversion. Digits only change on done.
// Optional feature macro: LEADING_ZERO_BLANK_EN (leading-zero blanking on blank_o).
module hex_digit_feeder #(
    parameter int DIGITS = 8,
    parameter int VAL_W  = 32
) (
    input logic               clk,
    input logic               rst_n,
    hex_digit_feeder_if.slave bus
);

    localparam int DW    = 4 * DIGITS;
    localparam int CNT_W = $clog2(VAL_W);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(VAL_W - 1);

    // Largest decimal value that fits on DIGITS digits: 10^DIGITS - 1.
    function automatic logic [VAL_W-1:0] f_dec_max(input int n);
        logic [VAL_W-1:0] p;
        p = VAL_W'(1);
        for (int k = 0; k < n; k++) p = p * VAL_W'(10);
        return p - VAL_W'(1);
    endfunction

    localparam logic [VAL_W-1:0] DEC_MAX = f_dec_max(DIGITS);

    typedef enum logic [1:0] {IDLE, CONV, PUB} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [VAL_W-1:0] r_bin;
    logic [DW-1:0]    r_bcd;
    logic [CNT_W-1:0] r_cnt;
    logic [DW-1:0]    r_digit;
    logic             r_ovf;
    logic             r_done;

    logic [DW-1:0]    w_bcd_adj;
    logic [DW-1:0]    w_bcd_shift;
    logic             w_hex_ovf;
    logic             w_dec_ovf;
    logic             w_start_conv;
    logic             w_shift;
    logic             w_load;
    logic [DW-1:0]    w_load_digits;
    logic             w_load_ovf;

    // Double-dabble step and write-side overflow detection.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        w_bcd_adj = r_bcd;
        w_hex_ovf = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
        w_bcd_shift = {w_bcd_adj[DW-2:0], r_bin[VAL_W-1]};
        for (int b = DW; b < VAL_W; b++) w_hex_ovf = w_hex_ovf | bus.wr_data[b];
        w_dec_ovf = (bus.wr_data > DEC_MAX);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control: a write in any state restarts from IDLE behaviour.
    always_comb begin
        w_state_nxt   = r_state;
        w_start_conv  = 1'b0;
        w_shift       = 1'b0;
        w_load        = 1'b0;
        w_load_digits = '0;
        w_load_ovf    = 1'b0;
        if (bus.wr_en) begin
            if (!bus.dec_mode) begin
                w_load        = 1'b1;
                w_load_digits = bus.wr_data[DW-1:0];
                w_load_ovf    = w_hex_ovf;
                w_state_nxt   = PUB;
            end else if (w_dec_ovf) begin
                w_load        = 1'b1;
                w_load_digits = {DIGITS{4'hE}};
                w_load_ovf    = 1'b1;
                w_state_nxt   = PUB;
            end else begin
                w_start_conv  = 1'b1;
                w_state_nxt   = CONV;
            end
        end else begin
            case (r_state)
                IDLE: ;
                CONV: begin
                    w_shift = 1'b1;
                    if (r_cnt == LAST_SHIFT) begin
                        w_load        = 1'b1;
                        w_load_digits = w_bcd_shift;
                        w_state_nxt   = PUB;
                    end
                end
                PUB:     w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Conversion datapath: binary shifter, BCD accumulator and shift counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
        end else if (w_start_conv) begin
            r_bin <= bus.wr_data;
            r_bcd <= '0;
            r_cnt <= '0;
        end else if (w_shift) begin
            r_bin <= r_bin << 1;
            r_bcd <= w_bcd_shift;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Published outputs: loaded on entry to PUB, so done and the new digits appear together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit <= '0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_load;
            if (w_load) begin
                r_digit <= w_load_digits;
                r_ovf   <= w_load_ovf;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // blank[i] is set when digit i and every higher digit are zero; digit 0 is never blanked.
    // The decimal-overflow pattern is all 4'hE, so it naturally yields no blanking.
    function automatic logic [DIGITS-1:0] f_blank(input logic [DW-1:0] d);
        logic [DIGITS-1:0] res;
        logic              zero_above;
        res        = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (d[4*i +: 4] == 4'h0);
            res[i]     = zero_above;
        end
        return res;
    endfunction

    logic [DIGITS-1:0] r_blank;

    // Blank mask register, updated together with the digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blank <= '0;
        end else if (w_load) begin
            r_blank <= f_blank(w_load_digits);
        end
    end

    assign bus.blank_o = r_blank;
`else
    assign bus.blank_o = '0;
`endif

    assign bus.digit_o = r_digit;
    assign bus.ovf     = r_ovf;
    assign bus.done    = r_done;
    assign bus.busy    = (r_state == CONV);

endmodule

// File: tb/tb_hex_digit_feeder.sv
// Self-checking bench for hex_digit_feeder (DIGITS=8): directed vector table,
// multi-write/reset sequences, and random writes against an arithmetic model.
module tb_hex_digit_feeder;

    localparam int DIGITS = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hex_digit_feeder_if #(.DIGITS(DIGITS), .VAL_W(32)) bus ();

    hex_digit_feeder #(.DIGITS(DIGITS), .VAL_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] data;
        logic        dec;
        logic [31:0] dig;
        logic [7:0]  blk_lzb;  // expected blank mask when blanking is built
        logic        ovf;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_blank(input logic [7:0] lzb);
`ifdef LEADING_ZERO_BLANK_EN
        return lzb;
`else
        return (lzb & 8'h00);
`endif
    endfunction

    // Reference model: digits from plain division, blanking from "value above digit i is zero".
    function automatic void model(input logic [31:0] v, input logic dec,
                                  output logic [31:0] dig, output logic [7:0] blk,
                                  output logic ovf, output int lat);
        int unsigned x;
        longint unsigned lim;
        lim = 1;
        for (int i = 0; i < DIGITS; i++) lim = lim * 10;
        dig = '0;
        blk = '0;
        if (!dec) begin
            dig = v;
            ovf = ((longint'(v) >> (4 * DIGITS)) != 0);
            lat = 1;
        end else if (longint'(v) >= lim) begin
            dig = 32'hEEEE_EEEE;
            ovf = 1'b1;
            lat = 1;
        end else begin
            x = v;
            for (int i = 0; i < DIGITS; i++) begin
                dig[4*i +: 4] = 4'(x % 10);
                x = x / 10;
            end
            ovf = 1'b0;
            lat = 33;
        end
`ifdef LEADING_ZERO_BLANK_EN
        if (!(dec && ovf)) begin
            for (int i = 1; i < DIGITS; i++) blk[i] = ((dig >> (4 * i)) == 0);
        end
`endif
    endfunction

    task automatic do_write(input logic [31:0] d, input logic dec);
        @(negedge clk);
        bus.wr_en    = 1'b1;
        bus.wr_data  = d;
        bus.dec_mode = dec;
        @(negedge clk);
        bus.wr_en    = 1'b0;
    endtask

    // Called at the negedge after the write edge (cycle 1); returns -1 on timeout.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 1;
        busy_cnt = 0;
        while (!bus.done && lat < 100) begin
            if (bus.busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        if (!bus.done) lat = -1;
    endtask

    task automatic apply(input string tag, input logic [31:0] d, input logic dec,
                         input logic [31:0] dig, input logic [7:0] blk,
                         input logic ovf, input int lat);
        int got_lat, got_busy;
        do_write(d, dec);
        wait_done(got_lat, got_busy);
        check({tag, " latency"}, got_lat, lat);
        check({tag, " busy_cycles"}, got_busy, (lat == 33) ? 32 : 0);
        check({tag, " digit_o"}, bus.digit_o, dig);
        check({tag, " blank_o"}, bus.blank_o, blk);
        check({tag, " ovf"}, bus.ovf, ovf);
        @(negedge clk);
        check({tag, " done_pulse"}, bus.done, 1'b0);
        check({tag, " digit_hold"}, bus.digit_o, dig);
    endtask

    // Up to two writes at chosen cycles; records done count and digits at first/last done.
    task automatic run_seq(input int n, input int c0, input logic [31:0] d0, input logic m0,
                           input int c1, input logic [31:0] d1, input logic m1,
                           output int ndone, output int first_c, output int last_c,
                           output logic [31:0] first_dig, output logic [31:0] last_dig);
        ndone = 0; first_c = -1; last_c = -1; first_dig = '0; last_dig = '0;
        @(negedge clk);
        for (int c = 0; c < n; c++) begin
            bus.wr_en = 1'b0;
            if (c == c0) begin bus.wr_en = 1'b1; bus.wr_data = d0; bus.dec_mode = m0; end
            if (c == c1) begin bus.wr_en = 1'b1; bus.wr_data = d1; bus.dec_mode = m1; end
            @(negedge clk);
            if (bus.done) begin
                ndone++;
                if (first_c < 0) begin first_c = c + 1; first_dig = bus.digit_o; end
                last_c   = c + 1;
                last_dig = bus.digit_o;
            end
        end
        bus.wr_en = 1'b0;
    endtask

    initial begin
        int nd, fc, lc, rl, rb, dc;
        logic [31:0] fd, ld, m_dig, v;
        logic [7:0]  m_blk;
        logic        m_ovf, dm;
        int          m_lat;

        vecs[0]  = '{32'h1234_ABCD, 1'b0, 32'h1234_ABCD, 8'h00, 1'b0, 1};
        vecs[1]  = '{32'd12345678,  1'b1, 32'h1234_5678, 8'h00, 1'b0, 33};
        vecs[2]  = '{32'd100000000, 1'b1, 32'hEEEE_EEEE, 8'h00, 1'b1, 1};
        vecs[3]  = '{32'd0,         1'b1, 32'h0000_0000, 8'hFE, 1'b0, 33};
        vecs[4]  = '{32'h0,         1'b0, 32'h0000_0000, 8'hFE, 1'b0, 1};
        vecs[5]  = '{32'hA5,        1'b0, 32'h0000_00A5, 8'hFC, 1'b0, 1};
        vecs[6]  = '{32'd99999999,  1'b1, 32'h9999_9999, 8'h00, 1'b0, 33};
        vecs[7]  = '{32'd255,       1'b1, 32'h0000_0255, 8'hF8, 1'b0, 33};
        vecs[8]  = '{32'h0001_0000, 1'b0, 32'h0001_0000, 8'hE0, 1'b0, 1};
        vecs[9]  = '{32'd7,         1'b1, 32'h0000_0007, 8'hFE, 1'b0, 33};
        vecs[10] = '{32'hFFFF_FFFF, 1'b1, 32'hEEEE_EEEE, 8'h00, 1'b1, 1};

        bus.wr_en = 1'b0; bus.wr_data = '0; bus.dec_mode = 1'b0;
        repeat (3) @(negedge clk);
        check("reset digit_o", bus.digit_o, 32'h0);
        check("reset blank_o", bus.blank_o, 8'h0);
        check("reset busy", bus.busy, 1'b0);
        check("reset done", bus.done, 1'b0);
        check("reset ovf", bus.ovf, 1'b0);
        rst_n = 1'b1;

        // Directed vector table.
        foreach (vecs[i])
            apply($sformatf("vec%0d", i), vecs[i].data, vecs[i].dec, vecs[i].dig,
                  exp_blank(vecs[i].blk_lzb), vecs[i].ovf, vecs[i].lat);

        // Restart during conversion: only the second write completes.
        run_seq(60, 0, 32'd99, 1'b1, 10, 32'd7, 1'b1, nd, fc, lc, fd, ld);
        check("restart done_count", nd, 1);
        check("restart done_cycle", fc, 43);
        check("restart digit_o", ld, 32'h7);
        check("restart blank_o", bus.blank_o, exp_blank(8'hFE));

        // Write in the PUB cycle: both publishes happen back to back.
        run_seq(5, 0, 32'h11, 1'b0, 1, 32'h22, 1'b0, nd, fc, lc, fd, ld);
        check("pubwr done_count", nd, 2);
        check("pubwr cycles", {fc[15:0], lc[15:0]}, {16'd1, 16'd2});
        check("pubwr digits", {fd, ld}, {32'h11, 32'h22});

        run_seq(40, 0, 32'd5, 1'b1, 33, 32'h33, 1'b0, nd, fc, lc, fd, ld);
        check("convpub done_count", nd, 2);
        check("convpub cycles", {fc[15:0], lc[15:0]}, {16'd33, 16'd34});
        check("convpub digits", {fd, ld}, {32'h5, 32'h33});

        // Reset during conversion: immediate clear, nothing published afterwards.
        run_seq(15, 0, 32'hFFFF, 1'b1, -1, 32'h0, 1'b0, nd, fc, lc, fd, ld);
        check("rstconv early_done", nd, 0);
        check("rstconv busy_before", bus.busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rstconv digit_o", bus.digit_o, 32'h0);
        check("rstconv busy", bus.busy, 1'b0);
        check("rstconv done", bus.done, 1'b0);
        check("rstconv ovf_blank", {bus.ovf, bus.blank_o}, 9'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dc = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done) dc++;
        end
        check("rstconv no_done", dc, 0);
        apply("post_reset_hex", 32'hA5, 1'b0, 32'hA5, exp_blank(8'hFC), 1'b0, 1);

        // Random writes against the model.
        for (int n = 0; n < 250; n++) begin
            case ($urandom_range(0, 3))
                0:       v = $urandom_range(0, 999);
                1:       v = $urandom;
                2:       v = $urandom_range(99999990, 100000010);
                default: v = 32'h1 << $urandom_range(0, 31);
            endcase
            dm = 1'($urandom_range(0, 1));
            model(v, dm, m_dig, m_blk, m_ovf, m_lat);
            do_write(v, dm);
            wait_done(rl, rb);
            check($sformatf("rand%0d latency", n), rl, m_lat);
            check($sformatf("rand%0d busy", n), rb, (m_lat == 33) ? 32 : 0);
            check($sformatf("rand%0d out v=%0h d=%0b", n, v, dm),
                  {bus.ovf, bus.blank_o, bus.digit_o}, {m_ovf, m_blk, m_dig});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
